// File: rtl/mc_alu_control_fsm.sv
// Multicycle CPU control: decodes op/func and sequences IF/ID/EXE/MEM/WB, driving ALU code, mux selects and write enables.
// Latency: one FSM step per clock; all outputs are combinational from state, op, func and z.
// Backpressure: none; the sequencer never stalls. Reset forces every output low and returns the FSM to IF.
module mc_alu_control_fsm #(
  parameter int ILL_TRAP = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  output logic [3:0] aluc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       shift,
  output logic       sext,
  output logic [1:0] pcsource,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ILL = 3'd5
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  state_e state_q, state_d;

  logic r_type;
  logic r_add, r_sub, r_and, r_or, r_xor, r_sll, r_srl, r_sra, r_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic is_shift, is_itype_wb, decoded;

  // Instruction decode; func only matters for op==0.
  always_comb begin
    r_type = (op == 6'h00);
    r_add  = r_type && (func == 6'h20);
    r_sub  = r_type && (func == 6'h22);
    r_and  = r_type && (func == 6'h24);
    r_or   = r_type && (func == 6'h25);
    r_xor  = r_type && (func == 6'h26);
    r_sll  = r_type && (func == 6'h00);
    r_srl  = r_type && (func == 6'h02);
    r_sra  = r_type && (func == 6'h03);
    r_jr   = r_type && (func == 6'h08);
    i_j    = (op == 6'h02);
    i_jal  = (op == 6'h03);
    i_beq  = (op == 6'h04);
    i_bne  = (op == 6'h05);
    i_addi = (op == 6'h08);
    i_andi = (op == 6'h0c);
    i_ori  = (op == 6'h0d);
    i_xori = (op == 6'h0e);
    i_lui  = (op == 6'h0f);
    i_lw   = (op == 6'h23);
    i_sw   = (op == 6'h2b);
    is_shift    = r_sll || r_srl || r_sra;
    // I-type results that land in the register file, addressed by rt.
    is_itype_wb = i_addi || i_andi || i_ori || i_xori || i_lui || i_lw;
    decoded = r_add || r_sub || r_and || r_or || r_xor || is_shift || r_jr ||
              i_addi || i_andi || i_ori || i_xori || i_lw || i_sw ||
              i_beq || i_bne || i_lui || i_j || i_jal;
  end

  // Next-state and control outputs; reset overrides every output last.
  always_comb begin
    state_d  = state_q;
    aluc     = ALU_ADD;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    shift    = 1'b0;
    sext     = 1'b0;
    pcsource = 2'b00;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    illegal  = 1'b0;
    state    = state_q;

    case (state_q)
      S_IF: begin
        wir     = 1'b1;
        wpc     = 1'b1;
        alusrcb = 2'b01;
        state_d = S_ID;
      end
      S_ID: begin
        // Branch target is computed here speculatively and parked in the ALU register.
        alusrcb = 2'b11;
        sext    = 1'b1;
        if (i_j) begin
          wpc      = 1'b1;
          pcsource = 2'b11;
          state_d  = S_IF;
        end else if (r_jr) begin
          wpc      = 1'b1;
          pcsource = 2'b10;
          state_d  = S_IF;
        end else if (i_jal) begin
          wpc      = 1'b1;
          pcsource = 2'b11;
          wreg     = 1'b1;
          jal      = 1'b1;
          state_d  = S_IF;
        end else if (!decoded) begin
          illegal  = 1'b1;
          state_d  = (ILL_TRAP != 0) ? S_ILL : S_IF;
        end else begin
          state_d  = S_EXE;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        alusrcb = (r_type || i_beq || i_bne) ? 2'b00 : 2'b10;
        shift   = is_shift;
        sext    = i_addi || i_lw || i_sw || i_beq || i_bne;
        if (r_sub || i_beq || i_bne)  aluc = ALU_SUB;
        else if (r_and || i_andi)     aluc = ALU_AND;
        else if (r_or || i_ori)       aluc = ALU_OR;
        else if (r_xor || i_xori)     aluc = ALU_XOR;
        else if (i_lui)               aluc = ALU_LUI;
        else if (r_sll)               aluc = ALU_SLL;
        else if (r_srl)               aluc = ALU_SRL;
        else if (r_sra)               aluc = ALU_SRA;
        else                          aluc = ALU_ADD;
        if (i_beq || i_bne) begin
          wpc      = i_beq ? z : ~z;
          pcsource = 2'b01;
          state_d  = S_IF;
        end else if (i_lw || i_sw) begin
          state_d  = S_MEM;
        end else begin
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        iord    = 1'b1;
        wmem    = i_sw;
        state_d = i_lw ? S_WB : S_IF;
      end
      S_WB: begin
        wreg    = 1'b1;
        regrt   = is_itype_wb;
        m2reg   = i_lw;
        state_d = S_IF;
      end
      S_ILL: begin
        illegal = 1'b1;
        state_d = S_ILL;
      end
      default: begin
        state_d = S_IF;
      end
    endcase

    if (reset) begin
      aluc     = 4'b0000;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      shift    = 1'b0;
      sext     = 1'b0;
      pcsource = 2'b00;
      wpc      = 1'b0;
      wir      = 1'b0;
      wmem     = 1'b0;
      wreg     = 1'b0;
      iord     = 1'b0;
      regrt    = 1'b0;
      m2reg    = 1'b0;
      jal      = 1'b0;
      illegal  = 1'b0;
      state    = 3'd0;
    end
  end

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

endmodule
